huffman_gen: RTL and testbench
==============================

HUFFMAN_GEN -- requirements
Module: huffman_gen

Interface
REQ-001 SHALL have parameter N_SYM, default 6, number of symbols (legal 2..8); symbol values 1..N_SYM.
REQ-002 SHALL have parameter DATA_W, default 8, input sample width.
REQ-003 SHALL have parameter CNT_W, default 8, per-symbol count width.
REQ-004 SHALL have parameter CODE_W, default 8, code/mask width per symbol (legal CODE_W >= N_SYM-1).
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port gray_valid  input  1  sample valid.
REQ-008 SHALL have port gray_data  input  DATA_W  sample symbol value.
REQ-009 SHALL have port gray_last  input  1  marks the final sample of a frame; qualified by gray_valid.
REQ-010 SHALL have port gray_ready  output  1  high when samples are accepted (COUNT state only).
REQ-011 SHALL have port CNT_valid  output  1  one-cycle pulse; cnt_flat is valid from this cycle.
REQ-012 SHALL have port cnt_flat  output  N_SYM*CNT_W  count of symbol k+1 at bits [k*CNT_W +: CNT_W].
REQ-013 SHALL have port code_valid  output  1  one-cycle pulse; hc_flat and mask_flat are valid from this cycle.
REQ-014 SHALL have port hc_flat  output  N_SYM*CODE_W  right-aligned code of symbol k+1 at [k*CODE_W +: CODE_W].
REQ-015 SHALL have port mask_flat  output  N_SYM*CODE_W  mask (2^len-1) of symbol k+1, same packing.

Function
REQ-016 SHALL implement FSM states COUNT, LATCH, SELECT, MERGE, DONE; COUNT->LATCH on an accepted gray_last; LATCH->SELECT; SELECT->MERGE; MERGE->SELECT while merges < N_SYM-1, else ->DONE; DONE->COUNT.
REQ-017 SHALL accept a sample when gray_valid && gray_ready; each accepted sample with value v in 1..N_SYM increments count v; other values are not counted.
REQ-018 SHALL end the frame on any accepted sample with gray_last=1, counting that sample if in range.
REQ-019 SHALL assert CNT_valid in LATCH, i.e. the cycle after the accepted gray_last, and update cnt_flat in that cycle.
REQ-020 SHALL load group slots s=0..N_SYM-1 in LATCH with count(s+1), member set {s}, code 0 and length 0 for every symbol; group sums SHALL use CNT_W+3 bits.
REQ-021 SHALL, in SELECT, choose m1 = the active slot with minimum sum (ties: highest slot index), then m2 = the same rule over the remaining active slots.
REQ-022 SHALL, in MERGE, OR bit 1 at position len into each m1 member's code, OR bit 0 at position len into each m2 member's code, increment len of all members, move m1's members and sum into m2, and deactivate m1.
REQ-023 SHALL assert code_valid in DONE, exactly 2*(N_SYM-1)+1 cycles after CNT_valid, and update hc_flat and mask_flat in that cycle.
REQ-024 SHALL hold cnt_flat until the next CNT_valid and hc_flat/mask_flat until the next code_valid.
REQ-025 SHALL clear the internal counters on entering COUNT from DONE; gray_ready SHALL be low in LATCH through DONE, and gray_valid SHALL be ignored there.
REQ-026 SHALL treat zero-count symbols as normal leaves.

Reset
REQ-027 SHALL, on reset, force COUNT state, zero all counters, and drive gray_ready=1 and CNT_valid=0, code_valid=0, cnt_flat=0, hc_flat=0, mask_flat=0.
REQ-028 SHALL, when reset is asserted mid-frame or mid-build, abandon the operation, emit no pulses, and restart in COUNT.

Configuration
REQ-029 SHALL, with macro HUFFMAN_GEN_SAT_EN defined, saturate each counter at 2^CNT_W-1; without it, counters wrap modulo 2^CNT_W.

Verification
REQ-030 Frame of 100 samples, counts sym1..6 = 40,20,15,10,10,5 -> CNT_valid once; counts match; 11 cycles later code_valid; HC=01,00,01,03,04,05 hex; M=01,07,07,07,0F,0F hex.
REQ-031 300 samples of value 2, last flagged -> CNT2 = 255 with HUFFMAN_GEN_SAT_EN, 44 without; all other counts 0.
REQ-032 Samples of values 0, 7, 255 interleaved with 10 samples of value 3; gray_last on value 0 -> only CNT3=10; frame ends anyway.
REQ-033 gray_valid held high from LATCH to DONE -> gray_ready low; no count change; next frame's counts start at 0.
REQ-034 Reset asserted in the third MERGE cycle -> no code_valid; outputs 0; a fresh frame completes normally.
REQ-035 N_SYM=2, counts 3,3 -> code_valid 3 cycles after CNT_valid; HC1=0, HC2=1; both masks 01 hex.

Source files
------------

// File: rtl/huffman_gen.sv
// huffman_gen: per-frame symbol histogram followed by a Huffman code build.
//
// Samples are counted while in COUNT. An accepted gray_last closes the frame.
// The counts are then published, and N_SYM-1 SELECT/MERGE rounds build one
// right-aligned code and one length mask for every symbol.
//
// Parameters:
//   N_SYM  - number of symbols (2..8); symbol values are 1..N_SYM
//   DATA_W - sample width
//   CNT_W  - per-symbol counter width
//   CODE_W - code/mask width per symbol (>= N_SYM-1)
//
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   gray_valid  - sample valid; gray_data carries the sample; gray_last ends the frame
//   gray_ready  - high only in COUNT
//   CNT_valid   - one-cycle pulse; cnt_flat holds count of symbol k+1 at [k*CNT_W +: CNT_W]
//   code_valid  - one-cycle pulse; hc_flat/mask_flat hold code and mask of symbol k+1
//                 at [k*CODE_W +: CODE_W]
//
// Build option: define HUFFMAN_GEN_SAT_EN to make the counters saturate instead of wrap.

module huffman_gen #(
    parameter int unsigned N_SYM  = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned CODE_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      gray_valid,
    input  logic [DATA_W-1:0]         gray_data,
    input  logic                      gray_last,
    output logic                      gray_ready,
    output logic                      CNT_valid,
    output logic [N_SYM*CNT_W-1:0]    cnt_flat,
    output logic                      code_valid,
    output logic [N_SYM*CODE_W-1:0]   hc_flat,
    output logic [N_SYM*CODE_W-1:0]   mask_flat
);

    localparam int unsigned SUM_W      = CNT_W + 3;
    localparam int unsigned IDX_W      = (N_SYM > 1) ? $clog2(N_SYM) : 1;
    localparam logic [3:0]  LAST_MERGE = 4'(N_SYM - 2);

    typedef enum logic [2:0] {StCount, StLatch, StSelect, StMerge, StDone} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q    [N_SYM];
    logic [CNT_W-1:0]  cnt_d    [N_SYM];
    logic [SUM_W-1:0]  sum_q    [N_SYM];
    logic [SUM_W-1:0]  sum_d    [N_SYM];
    logic [N_SYM-1:0]  memb_q   [N_SYM];
    logic [N_SYM-1:0]  memb_d   [N_SYM];
    logic [CODE_W-1:0] code_q   [N_SYM];
    logic [CODE_W-1:0] code_d   [N_SYM];
    logic [CODE_W-1:0] mask_q   [N_SYM];
    logic [CODE_W-1:0] mask_d   [N_SYM];
    logic [N_SYM-1:0]  active_q, active_d;
    logic [IDX_W-1:0]  m1_q, m2_q, m1_sel, m2_sel;
    logic [3:0]        merges_q, merges_d;

    logic [N_SYM*CNT_W-1:0]  cnt_out_q, cnt_out_d;
    logic [N_SYM*CODE_W-1:0] hc_out_q, hc_out_d;
    logic [N_SYM*CODE_W-1:0] mask_out_q, mask_out_d;

    logic             found1, found2;
    logic [SUM_W-1:0] best1, best2;
    logic             accept, frame_end, last_merge;

    assign accept     = gray_valid && (state_q == StCount);
    assign frame_end  = accept && gray_last;
    assign last_merge = (state_q == StMerge) && (merges_q == LAST_MERGE);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCount:  if (frame_end) state_d = StLatch;
            StLatch:  state_d = StSelect;
            StSelect: state_d = StMerge;
            StMerge:  state_d = (merges_q == LAST_MERGE) ? StDone : StSelect;
            StDone:   state_d = StCount;
            default:  state_d = StCount;
        endcase
    end

    // ------------------------------------------------------------------
    // Histogram counters; cleared on the DONE -> COUNT transition
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < N_SYM; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (state_q == StDone) begin
            for (int k = 0; k < N_SYM; k++) begin
                cnt_d[k] = '0;
            end
        end else if (accept) begin
            for (int k = 0; k < N_SYM; k++) begin
                if (gray_data == DATA_W'(k + 1)) begin
`ifdef HUFFMAN_GEN_SAT_EN
                    if (cnt_q[k] != {CNT_W{1'b1}}) begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
`else
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
`endif
                end
            end
        end
    end

    // Published counts include the closing sample, so they come from cnt_d.
    always_comb begin
        cnt_out_d = cnt_out_q;
        if (frame_end) begin
            for (int k = 0; k < N_SYM; k++) begin
                cnt_out_d[k*CNT_W +: CNT_W] = cnt_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Minimum search. '<=' while scanning upward lets the highest index win ties.
    // ------------------------------------------------------------------
    always_comb begin
        m1_sel = '0;
        best1  = '0;
        found1 = 1'b0;
        for (int s = 0; s < N_SYM; s++) begin
            if (active_q[s] && (!found1 || sum_q[s] <= best1)) begin
                found1 = 1'b1;
                best1  = sum_q[s];
                m1_sel = IDX_W'(s);
            end
        end
        m2_sel = '0;
        best2  = '0;
        found2 = 1'b0;
        for (int s = 0; s < N_SYM; s++) begin
            if (active_q[s] && (IDX_W'(s) != m1_sel) && (!found2 || sum_q[s] <= best2)) begin
                found2 = 1'b1;
                best2  = sum_q[s];
                m2_sel = IDX_W'(s);
            end
        end
    end

    // ------------------------------------------------------------------
    // Group table: load in LATCH, merge m1 into m2 in MERGE
    // ------------------------------------------------------------------
    always_comb begin
        for (int s = 0; s < N_SYM; s++) begin
            sum_d[s]  = sum_q[s];
            memb_d[s] = memb_q[s];
            code_d[s] = code_q[s];
            mask_d[s] = mask_q[s];
        end
        active_d = active_q;
        merges_d = merges_q;

        if (state_q == StLatch) begin
            for (int s = 0; s < N_SYM; s++) begin
                sum_d[s]  = SUM_W'(cnt_q[s]);
                memb_d[s] = N_SYM'(1) << s;
                code_d[s] = '0;
                mask_d[s] = '0;
            end
            active_d = '1;
            merges_d = '0;
        end else if (state_q == StMerge) begin
            // mask = 2^len-1, so mask+1 is the one-hot bit at position len.
            for (int k = 0; k < N_SYM; k++) begin
                if (memb_q[m1_q][k]) begin
                    code_d[k] = code_q[k] | (mask_q[k] + CODE_W'(1));
                    mask_d[k] = (mask_q[k] << 1) | CODE_W'(1);
                end else if (memb_q[m2_q][k]) begin
                    mask_d[k] = (mask_q[k] << 1) | CODE_W'(1);
                end
            end
            sum_d[m2_q]    = sum_q[m2_q] + sum_q[m1_q];
            memb_d[m2_q]   = memb_q[m2_q] | memb_q[m1_q];
            memb_d[m1_q]   = '0;
            active_d[m1_q] = 1'b0;
            merges_d       = merges_q + 4'd1;
        end
    end

    // Codes are published from the final merge's next values so they appear in DONE.
    always_comb begin
        hc_out_d   = hc_out_q;
        mask_out_d = mask_out_q;
        if (last_merge) begin
            for (int k = 0; k < N_SYM; k++) begin
                hc_out_d[k*CODE_W +: CODE_W]   = code_d[k];
                mask_out_d[k*CODE_W +: CODE_W] = mask_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StCount;
            active_q   <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            merges_q   <= '0;
            cnt_out_q  <= '0;
            hc_out_q   <= '0;
            mask_out_q <= '0;
            for (int s = 0; s < N_SYM; s++) begin
                cnt_q[s]  <= '0;
                sum_q[s]  <= '0;
                memb_q[s] <= '0;
                code_q[s] <= '0;
                mask_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            merges_q   <= merges_d;
            cnt_out_q  <= cnt_out_d;
            hc_out_q   <= hc_out_d;
            mask_out_q <= mask_out_d;
            if (state_q == StSelect) begin
                m1_q <= m1_sel;
                m2_q <= m2_sel;
            end
            for (int s = 0; s < N_SYM; s++) begin
                cnt_q[s]  <= cnt_d[s];
                sum_q[s]  <= sum_d[s];
                memb_q[s] <= memb_d[s];
                code_q[s] <= code_d[s];
                mask_q[s] <= mask_d[s];
            end
        end
    end

    assign gray_ready = (state_q == StCount);
    assign CNT_valid  = (state_q == StLatch);
    assign code_valid = (state_q == StDone);
    assign cnt_flat   = cnt_out_q;
    assign hc_flat    = hc_out_q;
    assign mask_flat  = mask_out_q;

endmodule

// File: tb/tb_huffman_gen.sv
// tb_huffman_gen: directed self-checking bench for huffman_gen.
// A queue-based Huffman model predicts every output each cycle for the default
// six-symbol instance. Hand-computed literals pin that model. A second
// two-symbol instance is checked with literals only.

module tb_huffman_gen;

    localparam int NS = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        gray_valid = 1'b0;
    logic [7:0]  gray_data  = 8'd0;
    logic        gray_last  = 1'b0;
    logic        gray_ready, CNT_valid, code_valid;
    logic [47:0] cnt_flat, hc_flat, mask_flat;

    logic        g2_valid = 1'b0;
    logic [7:0]  g2_data  = 8'd0;
    logic        g2_last  = 1'b0;
    logic        g2_ready, cnt2_valid, code2_valid;
    logic [15:0] cnt2_flat, hc2_flat, mask2_flat;

    always #5 clk = ~clk;

    huffman_gen dut (
        .clk        (clk),
        .reset      (reset),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .gray_last  (gray_last),
        .gray_ready (gray_ready),
        .CNT_valid  (CNT_valid),
        .cnt_flat   (cnt_flat),
        .code_valid (code_valid),
        .hc_flat    (hc_flat),
        .mask_flat  (mask_flat)
    );

    huffman_gen #(.N_SYM(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .gray_valid (g2_valid),
        .gray_data  (g2_data),
        .gray_last  (g2_last),
        .gray_ready (g2_ready),
        .CNT_valid  (cnt2_valid),
        .cnt_flat   (cnt2_flat),
        .code_valid (code2_valid),
        .hc_flat    (hc2_flat),
        .mask_flat  (mask2_flat)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: histogram, then Huffman build over a queue of groups
    // with codes kept as bit strings (MSB first).
    // ------------------------------------------------------------------
    typedef struct {
        int       sum;
        int       idx;
        bit [7:0] syms;
    } grp_t;

    int          m_cnt [NS];
    int          m_pos = 0;     // 0: counting, 1..2*NS: cycles after frame end
    bit          e_cv = 1'b0;
    bit          e_kv = 1'b0;
    logic [47:0] e_cnt = '0, e_hc = '0, e_mask = '0, p_hc = '0, p_mask = '0;
    string       code_s [NS];

    task automatic model_build();
        grp_t g[$];
        grp_t a;
        int   ia, ib, v;
        for (int s = 0; s < NS; s++) begin
            code_s[s] = "";
            g.push_back('{sum: m_cnt[s], idx: s, syms: 8'(1 << s)});
        end
        while (g.size() > 1) begin
            ia = 0;
            for (int i = 1; i < g.size(); i++)
                if (g[i].sum < g[ia].sum || (g[i].sum == g[ia].sum && g[i].idx > g[ia].idx))
                    ia = i;
            a = g[ia];
            g.delete(ia);
            ib = 0;
            for (int i = 1; i < g.size(); i++)
                if (g[i].sum < g[ib].sum || (g[i].sum == g[ib].sum && g[i].idx > g[ib].idx))
                    ib = i;
            for (int s = 0; s < NS; s++) begin
                if (a.syms[s]) code_s[s] = {"1", code_s[s]};
                else if (g[ib].syms[s]) code_s[s] = {"0", code_s[s]};
            end
            g[ib].sum  = g[ib].sum + a.sum;
            g[ib].syms = g[ib].syms | a.syms;
        end
        for (int s = 0; s < NS; s++) begin
            v = 0;
            for (int i = 0; i < code_s[s].len(); i++)
                v = v * 2 + ((code_s[s].getc(i) == 8'h31) ? 1 : 0);
            p_hc[s*8 +: 8]   = 8'(v);
            p_mask[s*8 +: 8] = 8'((1 << code_s[s].len()) - 1);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos  = 0;
            e_cv   = 1'b0;
            e_kv   = 1'b0;
            e_cnt  = '0;
            e_hc   = '0;
            e_mask = '0;
            for (int s = 0; s < NS; s++) m_cnt[s] = 0;
        end else begin
            e_cv = 1'b0;
            e_kv = 1'b0;
            if (m_pos == 0) begin
                if (gray_valid) begin
                    if (int'(gray_data) >= 1 && int'(gray_data) <= NS) begin
`ifdef HUFFMAN_GEN_SAT_EN
                        if (m_cnt[gray_data-1] < 255) m_cnt[gray_data-1]++;
`else
                        m_cnt[gray_data-1] = (m_cnt[gray_data-1] + 1) % 256;
`endif
                    end
                    if (gray_last) begin
                        m_pos = 1;
                        e_cv  = 1'b1;
                        for (int s = 0; s < NS; s++) e_cnt[s*8 +: 8] = 8'(m_cnt[s]);
                        model_build();
                    end
                end
            end else if (m_pos == 2 * NS) begin
                m_pos = 0;
                for (int s = 0; s < NS; s++) m_cnt[s] = 0;
            end else begin
                m_pos++;
                if (m_pos == 2 * NS) begin
                    e_kv   = 1'b1;
                    e_hc   = p_hc;
                    e_mask = p_mask;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("gray_ready", gray_ready, (m_pos == 0));
        check("CNT_valid", CNT_valid, e_cv);
        check("code_valid", code_valid, e_kv);
        check("cnt_flat", cnt_flat, e_cnt);
        check("hc_flat", hc_flat, e_hc);
        check("mask_flat", mask_flat, e_mask);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int frame_q[$];

    task automatic send_frame(input bit hold);
        for (int i = 0; i < frame_q.size(); i++) begin
            gray_valid = 1'b1;
            gray_data  = 8'(frame_q[i]);
            gray_last  = (i == frame_q.size() - 1);
            @(posedge clk); #1;
        end
        gray_last = 1'b0;
        if (hold) begin
            gray_valid = 1'b1;
            gray_data  = 8'd1;
        end else begin
            gray_valid = 1'b0;
        end
    endtask

    // Called in the LATCH cycle; returns cycles until code_valid, then steps into COUNT.
    task automatic wait_code(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (code_valid) begin
                lat = k;
                break;
            end
        end
        gray_valid = 1'b0;
        if (lat < 0) check("code_valid timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic build_main_frame();
        int c [NS];
        c = '{40, 20, 15, 10, 10, 5};
        frame_q.delete();
        for (int r = 0; r < 40; r++)
            for (int s = 0; s < NS; s++)
                if (r < c[s]) frame_q.push_back(s + 1);
    endtask

    int lat;
    int pulses;

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset gray_ready", gray_ready, 1);
        check("reset CNT_valid", CNT_valid, 0);
        check("reset code_valid", code_valid, 0);
        check("reset hc_flat", hc_flat, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Main frame, gray_valid held high through the build.
        build_main_frame();
        send_frame(1'b1);
        check("A CNT_valid", CNT_valid, 1);
        check("A gray_ready", gray_ready, 0);
        check("A cnt_flat", cnt_flat, 48'h05_0A_0A_0F_14_28);
        wait_code(lat);
        check("A latency", lat, 11);
        check("A hc_flat", hc_flat, 48'h05_04_03_01_00_01);
        check("A mask_flat", mask_flat, 48'h0F_0F_07_07_07_01);

        // Counts restart at zero; some symbols are absent.
        frame_q = '{4, 4, 6, 1, 4, 6};
        send_frame(1'b0);
        check("D cnt_flat", cnt_flat, 48'h02_00_03_00_00_01);
        check("A hc held", hc_flat, 48'h05_04_03_01_00_01);
        wait_code(lat);
        check("D latency", lat, 11);

        // Counter overflow behaviour.
        frame_q.delete();
        for (int i = 0; i < 300; i++) frame_q.push_back(2);
        send_frame(1'b0);
`ifdef HUFFMAN_GEN_SAT_EN
        check("B cnt_flat", cnt_flat, 48'h00_00_00_00_FF_00);
`else
        check("B cnt_flat", cnt_flat, 48'h00_00_00_00_2C_00);
`endif
        wait_code(lat);

        // Out-of-range values ignored; frame ends on an uncounted sample.
        frame_q.delete();
        for (int i = 0; i < 10; i++) begin
            frame_q.push_back(3);
            frame_q.push_back((i % 3 == 0) ? 0 : ((i % 3 == 1) ? 7 : 255));
        end
        frame_q.push_back(0);
        send_frame(1'b0);
        check("C CNT_valid", CNT_valid, 1);
        check("C cnt_flat", cnt_flat, 48'h00_00_00_0A_00_00);
        wait_code(lat);

        // Reset during the third MERGE cycle.
        build_main_frame();
        send_frame(1'b0);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("E code_valid", code_valid, 0);
        check("E cnt_flat", cnt_flat, 0);
        check("E hc_flat", hc_flat, 0);
        check("E mask_flat", mask_flat, 0);
        check("E gray_ready", gray_ready, 1);
        @(posedge clk); #1 reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (code_valid) pulses++;
        end
        check("E no code_valid", pulses, 0);
        build_main_frame();
        send_frame(1'b0);
        check("E2 cnt_flat", cnt_flat, 48'h05_0A_0A_0F_14_28);
        wait_code(lat);
        check("E2 latency", lat, 11);
        check("E2 hc_flat", hc_flat, 48'h05_04_03_01_00_01);
        check("E2 mask_flat", mask_flat, 48'h0F_0F_07_07_07_01);

        // Two-symbol instance.
        for (int i = 0; i < 6; i++) begin
            g2_valid = 1'b1;
            g2_data  = 8'((i % 2) + 1);
            g2_last  = (i == 5);
            @(posedge clk); #1;
        end
        g2_valid = 1'b0;
        g2_last  = 1'b0;
        check("F CNT_valid", cnt2_valid, 1);
        check("F cnt_flat", cnt2_flat, 16'h0303);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (code2_valid) begin
                lat = k;
                break;
            end
        end
        check("F latency", lat, 3);
        check("F hc_flat", hc2_flat, 16'h0100);
        check("F mask_flat", mask2_flat, 16'h0101);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
